// File: rtl/hilo_muldiv.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring-divide step per cycle.
// Signed operations run on magnitudes; the sign fix-up is folded into the final RUN step.
module hilo_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    input  logic             annul_i,
    output logic             busy_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_DIVZERO = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi_w, lo_w, opd_mag;
    logic [WIDTH-1:0] hold_hi, hold_lo;
    logic             is_div, neg_q, neg_r;

    logic             accept, divzero_in, a_neg_in, b_neg_in, last_iter;
    logic [WIDTH-1:0] opa_mag_in, opb_mag_in;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] step_hi, step_lo, fin_hi, fin_lo;
    logic [2*WIDTH-1:0] prod_neg;

    // Handshake: start_i is a request sampled only in IDLE; ready_o is a one-cycle
    // valid strobe for hi_o/lo_o with no back-pressure; annul_i aborts and masks ready_o.
    assign accept     = start_i && !annul_i;
    assign divzero_in = op_i[1] && (opb_i == '0);
    assign a_neg_in   = !op_i[0] && opa_i[WIDTH-1];
    assign b_neg_in   = !op_i[0] && opb_i[WIDTH-1];
    assign opa_mag_in = a_neg_in ? -opa_i : opa_i;
    assign opb_mag_in = b_neg_in ? -opb_i : opb_i;
    assign last_iter  = (cnt == CNT_W'(WIDTH - 1));

    // Multiply: lo_w holds the multiplier and shifts right as product bits enter from hi_w.
    assign mul_sum   = {1'b0, hi_w} + (lo_w[0] ? {1'b0, opd_mag} : '0);
    // Divide: lo_w holds the dividend, shifting left while quotient bits enter at bit 0.
    assign div_shift = {hi_w, lo_w[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opd_mag};
    assign div_ok    = !div_diff[WIDTH];

    always_comb begin
        if (is_div) begin
            step_hi = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            step_lo = {lo_w[WIDTH-2:0], div_ok};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_w[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod_neg = -{step_hi, step_lo};
        if (is_div) begin
            fin_hi = neg_r ? -step_hi : step_hi;
            fin_lo = neg_q ? -step_lo : step_lo;
        end else begin
            fin_hi = neg_q ? prod_neg[2*WIDTH-1:WIDTH] : step_hi;
            fin_lo = neg_q ? prod_neg[WIDTH-1:0] : step_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (accept) state_nxt = divzero_in ? S_DIVZERO : S_RUN;
            S_RUN:     if (annul_i) state_nxt = S_IDLE;
                       else if (last_iter) state_nxt = S_DONE;
            S_DIVZERO: state_nxt = annul_i ? S_IDLE : S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o    = (state != S_IDLE);
        ready_o   = (state == S_DONE) && !annul_i;
        hi_o      = ready_o ? hi_w : hold_hi;
        lo_o      = ready_o ? lo_w : hold_lo;
        state_dbg = state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            hi_w    <= '0;
            lo_w    <= '0;
            opd_mag <= '0;
            is_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            hold_hi <= '0;
            hold_lo <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    cnt    <= '0;
                    is_div <= op_i[1];
                    neg_q  <= a_neg_in ^ b_neg_in;
                    neg_r  <= a_neg_in;
                    if (divzero_in) begin
                        hi_w    <= opa_i;
                        lo_w    <= '1;
                        opd_mag <= '0;
                    end else if (op_i[1]) begin
                        hi_w    <= '0;
                        lo_w    <= opa_mag_in;
                        opd_mag <= opb_mag_in;
                    end else begin
                        hi_w    <= '0;
                        lo_w    <= opb_mag_in;
                        opd_mag <= opa_mag_in;
                    end
                end
                S_RUN: if (!annul_i) begin
                    if (last_iter) begin
                        hi_w <= fin_hi;
                        lo_w <= fin_lo;
                    end else begin
                        cnt  <= cnt + CNT_W'(1);
                        hi_w <= step_hi;
                        lo_w <= step_lo;
                    end
                end
                S_DONE: if (!annul_i) begin
                    hold_hi <= hi_w;
                    hold_lo <= lo_w;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Bench for hilo_muldiv: directed and random MULT/MULTU/DIV/DIVU against an arithmetic model,
// plus annul, reset and start-while-busy scenarios.
module tb_hilo_muldiv;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start_i, annul_i;
    logic [1:0]   op_i;
    logic [W-1:0] opa_i, opb_i;
    logic         busy_o, ready_o;
    logic [W-1:0] hi_o, lo_o;
    logic [1:0]   state_dbg;

    int checks = 0;
    int errors = 0;
    logic [W-1:0]   hold_hi = '0;
    logic [W-1:0]   hold_lo = '0;
    logic [2*W-1:0] exp_q[$];

    hilo_muldiv #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .opa_i(opa_i), .opb_i(opb_i), .annul_i(annul_i),
        .busy_o(busy_o), .ready_o(ready_o), .hi_o(hi_o), .lo_o(lo_o),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Reference: plain 64-bit arithmetic; SV division truncates and % follows the dividend sign.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            2'b00: res = sa * sb;
            2'b01: res = ua * ub;
            default: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else if (op == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    res = {ur[31:0], uq[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    // Called at a falling edge with the DUT idle; returns at the falling edge of the next idle cycle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit hold_start);
        logic [63:0] exp;
        int lat;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL idle_busy got %b want 0", busy_o);
        end
        checks++;
        if (hi_o !== hold_hi || lo_o !== hold_lo) begin
            errors++; $display("FAIL hold got %h_%h want %h_%h", hi_o, lo_o, hold_hi, hold_lo);
        end
        exp_q.push_back(model(op, a, b));
        lat = (op[1] && b == 32'd0) ? 2 : W + 1;
        op_i = op; opa_i = a; opb_i = b; start_i = 1'b1;
        @(negedge clk);
        if (!hold_start) start_i = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            if (c > 1) @(negedge clk);
            checks++;
            if (busy_o !== 1'b1) begin
                errors++; $display("FAIL busy op=%0d cyc=%0d got %b want 1", op, c, busy_o);
            end
            checks++;
            if (ready_o !== (c == lat)) begin
                errors++; $display("FAIL ready op=%0d cyc=%0d got %b want %b", op, c, ready_o, c == lat);
            end
            if (c == lat) start_i = 1'b0;
            opa_i = $urandom; opb_i = $urandom; op_i = 2'($urandom_range(0, 3));
        end
        exp = exp_q.pop_front();
        checks++;
        if ({hi_o, lo_o} !== exp) begin
            errors++;
            $display("FAIL result op=%0d a=%h b=%h got %h_%h want %h_%h", op, a, b, hi_o, lo_o, exp[63:32], exp[31:0]);
        end
        hold_hi = exp[63:32];
        hold_lo = exp[31:0];
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; op_i = '0; opa_i = '0; opb_i = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || ready_o !== 1'b0 || hi_o !== '0 || lo_o !== '0) begin
            errors++; $display("FAIL reset got busy=%b ready=%b hi=%h lo=%h want 0", busy_o, ready_o, hi_o, lo_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_op(2'b11, 32'd100, 32'd7, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(2'b11, 32'd5, 32'd0, 1'b0);
        run_op(2'b10, 32'hFFFF_FF00, 32'd0, 1'b0);
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0);
    endtask

    task automatic test_annul_run();
        op_i = 2'b11; opa_i = 32'd123456; opb_i = 32'd77; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) @(negedge clk);
            checks++;
            if (busy_o !== 1'b1 || ready_o !== 1'b0) begin
                errors++; $display("FAIL annul_run_busy cyc=%0d got busy=%b ready=%b want 1/0", c, busy_o, ready_o);
            end
        end
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || ready_o !== 1'b0) begin
            errors++; $display("FAIL annul_run_idle got busy=%b ready=%b want 0/0", busy_o, ready_o);
        end
        checks++;
        if (hi_o !== hold_hi || lo_o !== hold_lo) begin
            errors++; $display("FAIL annul_run_hold got %h_%h want %h_%h", hi_o, lo_o, hold_hi, hold_lo);
        end
        run_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    endtask

    task automatic test_annul_done();
        op_i = 2'b00; opa_i = 32'hFFFF_0001; opb_i = 32'h0000_0333; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (W) @(negedge clk);
        annul_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b0 || hi_o !== hold_hi || lo_o !== hold_lo) begin
            errors++; $display("FAIL annul_done got ready=%b %h_%h want 0 %h_%h", ready_o, hi_o, lo_o, hold_hi, hold_lo);
        end
        @(negedge clk);
        annul_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || hi_o !== hold_hi || lo_o !== hold_lo) begin
            errors++; $display("FAIL annul_done_after got busy=%b %h_%h want 0 %h_%h", busy_o, hi_o, lo_o, hold_hi, hold_lo);
        end
    endtask

    task automatic test_start_annul_idle();
        op_i = 2'b01; opa_i = 32'd3; opb_i = 32'd4; start_i = 1'b1; annul_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; annul_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL start_annul_idle got busy=%b want 0", busy_o);
        end
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || ready_o !== 1'b0) begin
            errors++; $display("FAIL start_annul_later got busy=%b ready=%b want 0/0", busy_o, ready_o);
        end
    endtask

    task automatic test_reset_mid();
        op_i = 2'b00; opa_i = 32'h0BAD_F00D; opb_i = 32'hDEAD_0001; start_i = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 15; c++) begin
            if (c > 1) @(negedge clk);
            checks++;
            if (busy_o !== 1'b1 || ready_o !== 1'b0) begin
                errors++; $display("FAIL reset_mid_busy cyc=%0d got busy=%b ready=%b want 1/0", c, busy_o, ready_o);
            end
            opa_i = $urandom; opb_i = $urandom;
        end
        rst = 1'b1; annul_i = 1'b1;
        @(negedge clk);
        rst = 1'b0; annul_i = 1'b0; start_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || ready_o !== 1'b0 || hi_o !== '0 || lo_o !== '0) begin
            errors++; $display("FAIL reset_mid got busy=%b ready=%b hi=%h lo=%h want 0", busy_o, ready_o, hi_o, lo_o);
        end
        hold_hi = '0;
        hold_lo = '0;
        run_op(2'b11, 32'd1000, 32'd33, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic [31:0] corners[5];
        corners = '{32'd0, 32'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 32'($urandom);
            b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 32'($urandom);
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(1, 28);
            run_op(2'($urandom_range(0, 3)), a, b, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_annul_run();
        test_annul_done();
        test_start_annul_idle();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv.md
HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 Parameter: WIDTH, 32, operand width; HI and LO results are each WIDTH bits.
REQ-002 Parameter: CNT_W, 6, iteration counter width; SHALL satisfy 2^CNT_W > WIDTH.
REQ-003 Clocking: one clock, clk; rst is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start_i  input  1  request a new operation; sampled only in IDLE.
REQ-007 op_i  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-008 opa_i  input  WIDTH  multiplicand or dividend (reg1).
REQ-009 opb_i  input  WIDTH  multiplier or divisor (reg2).
REQ-010 annul_i  input  1  cancel any in-flight operation (branch flush or exception).
REQ-011 busy_o  output  1  stall request to the pipeline; high whenever state is not IDLE.
REQ-012 ready_o  output  1  one-cycle pulse; hi_o and lo_o are valid this cycle.
REQ-013 hi_o  output  WIDTH  product upper half, or remainder.
REQ-014 lo_o  output  WIDTH  product lower half, or quotient.

Function
REQ-015 States SHALL be IDLE, RUN, DIVZERO and DONE, with no other reachable state.
REQ-016 IDLE to RUN: start_i=1, annul_i=0, and the op is not a divide by zero; opa_i, opb_i and op_i are latched.
REQ-017 IDLE to DIVZERO: start_i=1, annul_i=0, op is DIV or DIVU, and opb_i=0.
REQ-018 RUN SHALL last exactly WIDTH cycles, one iteration per cycle (shift-add multiply or restoring divide), then go to DONE.
REQ-019 DIVZERO SHALL last one cycle, then go to DONE.
REQ-020 DONE SHALL last one cycle with ready_o=1, then go to IDLE.
REQ-021 Latency:
- normal operation: start accepted in cycle T, ready_o in cycle T+WIDTH+1;
- divide by zero: ready_o in cycle T+2.
REQ-022 Signed ops (MULT, DIV) SHALL iterate on operand magnitudes and apply the sign correction in the DONE transition.
- product is negated when the operand signs differ;
- quotient is negated when the operand signs differ;
- remainder takes the sign of the dividend.
REQ-023 Multiply SHALL form the full 2*WIDTH-bit product; hi_o gets the upper WIDTH bits, lo_o the lower WIDTH bits.
REQ-024 Overflow case: DIV of the most negative value by -1 SHALL give lo_o = most negative value and hi_o = 0, with no exception.
REQ-025 Divide by zero SHALL give hi_o = latched opa_i and lo_o = all ones, for both DIV and DIVU.
REQ-026 hi_o and lo_o SHALL hold their last DONE value until the next DONE; they are 0 after reset.
REQ-027 start_i SHALL be ignored while busy_o=1; the latched operands SHALL NOT change during an operation.
REQ-028 annul_i=1 in RUN, DIVZERO or DONE SHALL force IDLE on the next edge.
- ready_o is suppressed in that cycle if the state is DONE;
- hi_o and lo_o keep their previous values.
REQ-029 start_i and annul_i both high in IDLE: annul wins and the start is not accepted.
REQ-030 A new start SHALL be accepted in the IDLE cycle immediately after DONE (back-to-back issue; one bubble).
REQ-031 The iteration counter SHALL count from 0 to WIDTH-1 and never wrap within an operation.

Reset
REQ-032 rst=1 at a clock edge SHALL force IDLE and zero the counter and working registers.
- outputs after that edge: busy_o=0, ready_o=0, hi_o=0, lo_o=0.
REQ-033 Reset mid-operation SHALL abort the operation with no ready_o pulse; rst has priority over annul_i and start_i.

Verification (WIDTH=32)
REQ-034 DIVU 100/7, start in cycle T -> ready_o in T+33, lo_o=14, hi_o=2; busy_o high in T+1..T+33.
REQ-035 DIV 0xFFFFFFF9/2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
REQ-036 MULT 0xFFFFFFFD*5 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1; MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi_o=0xFFFFFFFE, lo_o=0x00000001.
REQ-037 DIVU 5/0, start in cycle T -> ready_o in T+2, hi_o=5, lo_o=0xFFFFFFFF.
REQ-038 annul_i pulsed in cycle T+10 of a DIVU -> busy_o=0 in T+11, no ready_o, prior hi_o/lo_o unchanged; a new MULTU started at T+11 completes correctly.
REQ-039 rst pulsed mid-RUN -> next cycle busy_o=0, hi_o=0, lo_o=0; start_i held high during RUN has no effect.
